// File: rtl/mem_bus_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_unit
// Purpose  : Memory-stage load/store bus unit. Turns one pipeline memory
//            request into a word-aligned bus transaction with byte enables.
//            It stalls the pipeline until the bus acknowledges. It returns the
//            raw load word together with addr[1:0] and the size code.
//            Misaligned requests raise an address exception and never reach
//            the bus.
// Options  : MBU_TIMEOUT_EN - when defined, a BUSY watchdog forces completion
//            after TIMEOUT cycles without bus_ack.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_a,
    output logic [2:0]  rsp_op,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        w_is_half;
    logic        w_is_byte;
    logic        w_misaligned;
    logic        w_accept;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;

    // Decode access size, alignment and the lane layout of the request.
    always_comb begin
        w_is_half    = (req_op == 3'b001);
        w_is_byte    = (req_op == 3'b010);
        w_misaligned = w_is_half ? req_addr[0]
                     : (w_is_byte ? 1'b0 : (req_addr[1:0] != 2'b00));
        w_accept     = (r_state == S_IDLE) && req_valid && !w_misaligned;
        if (!req_we) begin
            w_byteen = 4'b1111;
        end else if (w_is_half) begin
            w_byteen = req_addr[1] ? 4'b1100 : 4'b0011;
        end else if (w_is_byte) begin
            w_byteen = 4'b0001 << req_addr[1:0];
        end else begin
            w_byteen = 4'b1111;
        end
        if (w_is_half) begin
            w_wdata = {2{req_wdata[15:0]}};
        end else if (w_is_byte) begin
            w_wdata = {4{req_wdata[7:0]}};
        end else begin
            w_wdata = req_wdata;
        end
    end

    // Exceptions are raised in the same cycle, and only for a request seen in IDLE.
    assign exc_adel  = (r_state == S_IDLE) && req_valid && w_misaligned && !req_we;
    assign exc_ades  = (r_state == S_IDLE) && req_valid && w_misaligned &&  req_we;
    // The stall starts in the accept cycle and stays high until DONE.
    assign stall     = w_accept || (r_state == S_BUSY);
    assign bus_req   = (r_state == S_BUSY);
    assign rsp_valid = (r_state == S_DONE) && !bus_we;

`ifdef MBU_TIMEOUT_EN
    localparam logic [7:0] c_to_last = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;
    logic       r_to;

    assign bus_timeout = (r_state == S_DONE) && r_to;
`else
    localparam logic [7:0] c_unused_timeout = 8'(TIMEOUT);

    assign bus_timeout = 1'b0;
`endif

    // Transaction FSM. Bus fields are latched at accept and held through BUSY and DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_byteen <= 4'd0;
            bus_wdata  <= 32'd0;
            rsp_rdata  <= 32'd0;
            rsp_a      <= 2'd0;
            rsp_op     <= 3'd0;
`ifdef MBU_TIMEOUT_EN
            r_cnt      <= 8'd0;
            r_to       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_BUSY;
                        bus_we     <= req_we;
                        bus_addr   <= {req_addr[31:2], 2'b00};
                        bus_byteen <= w_byteen;
                        bus_wdata  <= w_wdata;
                        // Only loads move the response fields, so they stay coherent with rsp_rdata.
                        if (!req_we) begin
                            rsp_a  <= req_addr[1:0];
                            rsp_op <= req_op;
                        end
`ifdef MBU_TIMEOUT_EN
                        r_cnt      <= 8'd0;
                        r_to       <= 1'b0;
`endif
                    end
                end
                S_BUSY: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rsp_rdata <= bus_rdata;
                        end
                        r_state <= S_DONE;
`ifdef MBU_TIMEOUT_EN
                    // An ack in the expiry cycle takes the branch above, so it wins.
                    end else if (r_cnt == c_to_last) begin
                        if (!bus_we) begin
                            rsp_rdata <= 32'd0;
                        end
                        r_to    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
`endif
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
`ifdef MBU_TIMEOUT_EN
                    r_to    <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_unit.md
# mem_bus_unit

Memory-stage load/store bus unit. Converts a pipeline memory request (address, size, store data) into a single word-aligned data-bus transaction with byte enables, stalls the pipeline until the bus acknowledges, and hands the raw read word plus address low bits and size code to the downstream load-data extension stage. Misaligned accesses are flagged as address exceptions and never reach the bus.

## Interface
Parameters:
- TIMEOUT, 255: max BUSY cycles without bus_ack before a forced completion (only with MBU_TIMEOUT_EN); range 1–255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  memory instruction present in M stage.
- req_we  input  1  1 = store, 0 = load.
- req_op  input  3  size: 000 word, 001 half, 010 byte; other codes treated as word.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, value in low lanes.
- stall  output  1  freeze M stage and upstream.
- rsp_valid  output  1  one-cycle pulse: load word valid.
- rsp_rdata  output  32  raw bus word.
- rsp_a  output  2  req_addr[1:0] of the completed load.
- rsp_op  output  3  req_op of the completed load.
- exc_adel  output  1  misaligned load.
- exc_ades  output  1  misaligned store.
- bus_req  output  1  transaction request.
- bus_we  output  1  transaction is a write.
- bus_addr  output  32  {req_addr[31:2], 2'b00}.
- bus_byteen  output  4  write lane enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  transaction complete, sampled at rising edge.
- bus_rdata  input  32  read data, valid when bus_ack=1.
- bus_timeout  output  1  one-cycle pulse on forced completion.

## Operation
- States: IDLE, BUSY, DONE.
- Misaligned: word with addr[1:0]≠00, half with addr[0]=1. In IDLE with req_valid and misaligned: exc_adel (load) or exc_ades (store) high combinationally that cycle, stall=0, no bus access, stay IDLE.
- IDLE, req_valid, aligned: stall=1; at edge register bus_addr, bus_we, bus_byteen, bus_wdata, rsp_a, rsp_op; go BUSY.
- BUSY: bus_req=1, stall=1, bus outputs held stable. bus_ack=1 at edge: capture bus_rdata into rsp_rdata (loads), go DONE.
- DONE: stall=0, bus_req=0; rsp_valid=1 if load; req_valid ignored; go IDLE next edge.
- Byte enables: word 1111; half addr[1]?1100:0011; byte 0001<<addr[1:0]. Loads drive bus_byteen=1111.
- Write data: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- rsp_rdata, rsp_a, rsp_op hold until the next load captures.
- Reset (any state, incl. BUSY): immediately IDLE; bus_req, stall, rsp_valid, exc_*, bus_timeout, bus_we = 0; bus_addr, bus_byteen, bus_wdata, rsp_rdata, rsp_a, rsp_op = 0. Pending transaction abandoned; later bus_ack ignored outside BUSY.

## Timing
- Request seen in IDLE cycle 0; bus_req high from cycle 1; ack in cycle k≥1 → DONE in k+1. stall high cycles 0..k.
- Zero-wait bus: 3 cycles/access (IDLE, BUSY, DONE), stall high 2 cycles.
- Back-to-back accesses: DONE→IDLE adds one cycle; next request accepted in IDLE.
- exc_* same-cycle combinational; stall, rsp_valid, bus_req decode from registered state.

## Configuration
- MBU_TIMEOUT_EN defined: 8-bit counter cleared on BUSY entry, increments each BUSY cycle without ack; at count=TIMEOUT go DONE, rsp_rdata=0, rsp_valid=1 if load, bus_timeout pulse in DONE. Ack in the same cycle as expiry wins (normal completion, no bus_timeout).
- Not defined: no counter; BUSY waits indefinitely; bus_timeout tied 0.

## Test plan
- Load word 0x100, ack on 1st BUSY cycle, rdata 0xDEADBEEF → stall 2 cycles, rsp_valid 1 cycle, rsp_rdata 0xDEADBEEF, rsp_a 00, rsp_op 000.
- Store byte addr 0x103 wdata 0x000000A5, ack after 3 cycles → bus_byteen 1000, bus_wdata 0xA5A5A5A5, bus_addr 0x100, stall 4 cycles, no rsp_valid.
- Store half 0x102 wdata 0x1234 → byteen 1100, wdata 0x12341234; load half 0x101 → exc_adel=1, stall=0, bus_req never rises.
- reset driven low mid-BUSY, then released, late bus_ack → bus_req and stall drop asynchronously, FSM IDLE, no rsp_valid.
- MBU_TIMEOUT_EN, TIMEOUT=4, load, no ack → DONE after 4 BUSY cycles, rsp_valid with rsp_rdata 0, bus_timeout pulse; without macro, stall held 100+ cycles.
